tt_um_hoene_pwm_scheduler: RTL and testbench

Sequences colour updates into the LED PWM datapath. It takes decoded 32-bit words from the serial-to-parallel stage and the pwm_set strobe from the protocol block. Updates commit only on PWM period boundaries, so there is never a glitched duty cycle. It optionally fades linearly to new targets, and blanks the LED when the data stream stops. It sits between the protocol/serial2parallel pair and the led_pwm block.

---
 rtl/tt_um_hoene_pwm_scheduler_pkg.sv | 27 ++
 rtl/tt_um_hoene_pwm_fade_step.sv | 25 ++
 rtl/tt_um_hoene_pwm_scheduler.sv | 148 ++++++++++++++
 tb/tb_tt_um_hoene_pwm_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_pwm_scheduler_pkg.sv
// Shared definitions for the PWM update scheduler: command codes, FSM states
// and bit positions of the fields in the decoded 32-bit word.
package tt_um_hoene_pwm_scheduler_pkg;

    typedef enum logic [1:0] {
        CMD_SET   = 2'b00,
        CMD_FADE  = 2'b01,
        CMD_BLANK = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        FADING  = 2'b10
    } state_e;

    localparam int CMD_HI   = 31;
    localparam int CMD_LO   = 30;
    localparam int RED_HI   = 29;
    localparam int RED_LO   = 20;
    localparam int GREEN_HI = 19;
    localparam int GREEN_LO = 10;
    localparam int BLUE_HI  = 9;
    localparam int BLUE_LO  = 0;

endpackage

// File: rtl/tt_um_hoene_pwm_fade_step.sv
// One channel of the fade datapath: moves cur toward target by at most STEP,
// landing exactly on target instead of overshooting or wrapping.
module tt_um_hoene_pwm_fade_step #(
    parameter int WIDTH = 10,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] stepped
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    always_comb begin
        stepped = target;
        if (target > cur) begin
            if ((target - cur) > STEP_W) begin
                stepped = cur + STEP_W;
            end
        end else if ((cur - target) > STEP_W) begin
            stepped = cur - STEP_W;
        end
    end

endmodule

// File: rtl/tt_um_hoene_pwm_scheduler.sv
// Commits colour words to the PWM outputs only on period boundaries, with a
// period-count watchdog that blanks the LED. Fading is enabled by PWM_SCHED_FADE_EN.
module tt_um_hoene_pwm_scheduler
    import tt_um_hoene_pwm_scheduler_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int TIMEOUT_PERIODS = 1024,
    parameter int FADE_STEP       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_word,
    input  logic             in_set,
    input  logic             in_error,
    input  logic             in_period_end,
    output logic [WIDTH-1:0] out_red,
    output logic [WIDTH-1:0] out_green,
    output logic [WIDTH-1:0] out_blue,
    output logic             busy,
    output logic             timeout
);

    localparam logic [15:0] WD_MAX  = 16'(TIMEOUT_PERIODS);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_PERIODS - 1);

    state_e           state, next_state;
    cmd_e             in_cmd;
    logic [WIDTH-1:0] shadow_red, shadow_green, shadow_blue;
    logic [15:0]      wd_count;
    logic             accept, wd_fire, commit;

    assign in_cmd  = cmd_e'(in_word[CMD_HI:CMD_LO]);
    assign accept  = in_set && !in_error && (in_cmd != CMD_RSVD);
    // A set on the same edge restarts the watchdog, so it can never also fire.
    assign wd_fire = in_period_end && !accept && (wd_count == WD_LAST);
    assign busy    = (state == PENDING) || (state == FADING);

`ifdef PWM_SCHED_FADE_EN
    cmd_e             shadow_cmd;
    logic             fade_upd, fade_done;
    logic [WIDTH-1:0] step_red, step_green, step_blue;

    tt_um_hoene_pwm_fade_step #(.WIDTH(WIDTH), .STEP(FADE_STEP)) u_step_red (
        .cur(out_red), .target(shadow_red), .stepped(step_red));
    tt_um_hoene_pwm_fade_step #(.WIDTH(WIDTH), .STEP(FADE_STEP)) u_step_green (
        .cur(out_green), .target(shadow_green), .stepped(step_green));
    tt_um_hoene_pwm_fade_step #(.WIDTH(WIDTH), .STEP(FADE_STEP)) u_step_blue (
        .cur(out_blue), .target(shadow_blue), .stepped(step_blue));

    assign fade_done = (step_red == shadow_red) && (step_green == shadow_green)
                    && (step_blue == shadow_blue);
`endif

    always_comb begin
        next_state = state;
        commit     = 1'b0;
`ifdef PWM_SCHED_FADE_EN
        fade_upd   = 1'b0;
`endif
        if (wd_fire) begin
            next_state = IDLE;
        end else if (accept) begin
            next_state = PENDING;
        end else if (in_period_end) begin
            case (state)
                PENDING: begin
`ifdef PWM_SCHED_FADE_EN
                    if (shadow_cmd == CMD_FADE) begin
                        next_state = FADING;
                    end else begin
                        commit     = 1'b1;
                        next_state = IDLE;
                    end
`else
                    commit     = 1'b1;
                    next_state = IDLE;
`endif
                end
`ifdef PWM_SCHED_FADE_EN
                FADING: begin
                    fade_upd = 1'b1;
                    if (fade_done) begin
                        next_state = IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_red   <= '0;
            shadow_green <= '0;
            shadow_blue  <= '0;
`ifdef PWM_SCHED_FADE_EN
            shadow_cmd   <= CMD_SET;
`endif
            wd_count     <= '0;
            timeout      <= 1'b0;
            out_red      <= '0;
            out_green    <= '0;
            out_blue     <= '0;
        end else begin
            if (accept) begin
                // BLANK carries a zero target regardless of the colour fields.
                shadow_red   <= (in_cmd == CMD_BLANK) ? '0 : WIDTH'(in_word[RED_HI:RED_LO]);
                shadow_green <= (in_cmd == CMD_BLANK) ? '0 : WIDTH'(in_word[GREEN_HI:GREEN_LO]);
                shadow_blue  <= (in_cmd == CMD_BLANK) ? '0 : WIDTH'(in_word[BLUE_HI:BLUE_LO]);
`ifdef PWM_SCHED_FADE_EN
                shadow_cmd   <= in_cmd;
`endif
                wd_count     <= '0;
                timeout      <= 1'b0;
            end else if (in_period_end && (wd_count != WD_MAX)) begin
                wd_count <= wd_count + 16'd1;
            end

            if (wd_fire) begin
                out_red   <= '0;
                out_green <= '0;
                out_blue  <= '0;
                timeout   <= 1'b1;
            end else if (commit) begin
                out_red   <= shadow_red;
                out_green <= shadow_green;
                out_blue  <= shadow_blue;
            end
`ifdef PWM_SCHED_FADE_EN
            else if (fade_upd) begin
                out_red   <= step_red;
                out_green <= step_green;
                out_blue  <= step_blue;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tt_um_hoene_pwm_scheduler.sv
// Directed and randomized bench for the PWM update scheduler, checked against
// a per-edge behavioural model of the boundary/fade/watchdog rules.
module tb_tt_um_hoene_pwm_scheduler;

    localparam int WIDTH     = 10;
    localparam int TIMEOUT   = 1024;
    localparam int FADE_STEP = 4;
`ifdef PWM_SCHED_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      in_word;
    logic             in_set, in_error, in_period_end;
    logic [WIDTH-1:0] out_red, out_green, out_blue;
    logic             busy, timeout;

    int n_pass  = 0;
    int n_total = 0;

    int m_out[3];
    int m_tgt[3];
    int m_pend_tgt[3];
    int m_pend_cmd;
    int m_wd;
    bit m_pend, m_fading, m_to;

    tt_um_hoene_pwm_scheduler #(
        .WIDTH(WIDTH), .TIMEOUT_PERIODS(TIMEOUT), .FADE_STEP(FADE_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_set(in_set),
        .in_error(in_error), .in_period_end(in_period_end),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int cmd, input int r, input int g, input int b);
        return {cmd[1:0], r[9:0], g[9:0], b[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_red"},     32'(out_red),   32'(m_out[0]));
        check({tag, "_green"},   32'(out_green), 32'(m_out[1]));
        check({tag, "_blue"},    32'(out_blue),  32'(m_out[2]));
        check({tag, "_busy"},    32'(busy),      32'(m_pend || m_fading));
        check({tag, "_timeout"}, 32'(timeout),   32'(m_to));
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_out[c] = 0; m_tgt[c] = 0; m_pend_tgt[c] = 0;
        end
        m_pend_cmd = 0; m_wd = 0; m_pend = 0; m_fading = 0; m_to = 0;
    endtask

    // What one clock edge does, given the inputs sampled on it.
    task automatic model_edge(input bit set, input logic [31:0] word, input bit err, input bit pe);
        int  cmd, col[3], d, mv;
        bit  fired, done;
        cmd    = int'(word[31:30]);
        col[0] = int'(word[29:20]);
        col[1] = int'(word[19:10]);
        col[2] = int'(word[9:0]);
        if (set && !err && cmd != 3) begin
            m_pend = 1; m_pend_cmd = cmd; m_fading = 0; m_wd = 0; m_to = 0;
            for (int c = 0; c < 3; c++) m_pend_tgt[c] = (cmd == 2) ? 0 : col[c];
        end else if (pe) begin
            fired = 0;
            if (m_wd < TIMEOUT) begin
                m_wd++;
                fired = (m_wd == TIMEOUT);
            end
            if (fired) begin
                for (int c = 0; c < 3; c++) m_out[c] = 0;
                m_pend = 0; m_fading = 0; m_to = 1;
            end else if (m_pend) begin
                m_pend = 0;
                if (m_pend_cmd == 1 && FADE_EN) begin
                    m_fading = 1;
                    for (int c = 0; c < 3; c++) m_tgt[c] = m_pend_tgt[c];
                end else begin
                    for (int c = 0; c < 3; c++) m_out[c] = m_pend_tgt[c];
                end
            end else if (m_fading) begin
                done = 1;
                for (int c = 0; c < 3; c++) begin
                    d  = m_tgt[c] - m_out[c];
                    mv = (d < 0) ? -d : d;
                    if (mv > FADE_STEP) mv = FADE_STEP;
                    m_out[c] = (d < 0) ? m_out[c] - mv : m_out[c] + mv;
                    if (m_out[c] != m_tgt[c]) done = 0;
                end
                if (done) m_fading = 0;
            end
        end
    endtask

    task automatic step(input string tag, input bit set, input logic [31:0] word,
                        input bit err, input bit pe);
        @(negedge clk);
        in_set = set; in_word = word; in_error = err; in_period_end = pe;
        @(posedge clk);
        model_edge(set, word, err, pe);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_word = '0; in_set = 1'b0; in_error = 1'b0; in_period_end = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Plain SET: held until the boundary, then committed.
        step("set_cap", 1, mk(0, 10'h3FF, 10'h155, 10'h000), 0, 0);
        step("set_wait", 0, '0, 0, 0);
        step("set_commit", 0, '0, 0, 1);
        check("set_commit_red", 32'(out_red), 32'h3FF);
        check("set_commit_busy", 32'(busy), 32'h0);

        // Last set before a boundary wins.
        step("lw_first", 1, mk(0, 10'h100, 10'h001, 10'h002), 0, 0);
        step("lw_second", 1, mk(0, 10'h200, 10'h003, 10'h004), 0, 0);
        step("lw_commit", 0, '0, 0, 1);
        check("lw_red", 32'(out_red), 32'h200);

        // Rejected words: error flag and reserved command.
        step("rej_err", 1, mk(0, 10'h011, 10'h022, 10'h033), 1, 0);
        step("rej_rsvd", 1, mk(3, 10'h011, 10'h022, 10'h033), 0, 0);
        step("rej_pe", 0, '0, 0, 1);
        check("rej_red", 32'(out_red), 32'h200);

        // Set coincident with a boundary is held for the next one.
        step("coinc", 1, mk(0, 10'h055, 10'h066, 10'h077), 0, 1);
        step("coinc_commit", 0, '0, 0, 1);

        // BLANK forces a zero target.
        step("blank_cap", 1, mk(2, 10'h3FF, 10'h3FF, 10'h3FF), 0, 0);
        step("blank_commit", 0, '0, 0, 1);

        // Fade 0 -> red 10; four boundaries reach the target either way.
        step("fade_cap", 1, mk(1, 10, 0, 0), 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("fade_pe", 0, '0, 0, 1);
            step("fade_gap", 0, '0, 0, 0);
        end
        check("fade_end_red", 32'(out_red), 32'd10);
        check("fade_end_busy", 32'(busy), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 5) == 0, $urandom(),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end

        // Watchdog: rejected words mid-way must not restart it.
        step("wd_set", 1, mk(0, 10'h200, 10'h200, 10'h200), 0, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == 500) begin
                step("wd_rej_rsvd", 1, mk(3, 1, 2, 3), 0, 0);
                step("wd_rej_err", 1, mk(0, 1, 2, 3), 1, 0);
            end
            step("wd_pe", 0, '0, 0, 1);
            if (i == TIMEOUT - 1) check("wd_before", 32'(timeout), 32'h0);
        end
        check("wd_fired_to", 32'(timeout), 32'h1);
        check("wd_fired_red", 32'(out_red), 32'h0);
        step("wd_extra_pe", 0, '0, 0, 1);
        step("wd_clear", 1, mk(0, 10'h123, 10'h045, 10'h067), 0, 0);
        check("wd_clear_to", 32'(timeout), 32'h0);
        step("wd_recommit", 0, '0, 0, 1);
        check("wd_recommit_red", 32'(out_red), 32'h123);

        // Asynchronous reset mid fade/pending; nothing commits afterwards.
        step("ar_base", 1, mk(0, 10'h200, 10'h200, 10'h200), 0, 0);
        step("ar_base_pe", 0, '0, 0, 1);
        step("ar_fade", 1, mk(1, 10'h010, 10'h010, 10'h010), 0, 0);
        step("ar_pe1", 0, '0, 0, 1);
        step("ar_pend", 1, mk(1, 10'h3F0, 10'h3F0, 10'h3F0), 0, 0);
        @(negedge clk);
        in_set = 1'b0; in_period_end = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_pe1", 0, '0, 0, 1);
        step("post_rst_pe2", 0, '0, 0, 1);
        check("post_rst_red", 32'(out_red), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
